// File: rtl/lfsr_arbiter.sv
// Shared 32-bit shift-left LFSR handing out one random word per cycle to NUM_REQ round-robin requesters.
// Optional grant counter output draw_cnt_o is enabled by defining LFSR_ARB_DRAW_CNT_EN.
module lfsr_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          WARMUP_CYCLES = 16,
    parameter logic [31:0] DEFAULT_SEED  = 32'h00B41AFD
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               seed_valid_i,
    input  logic [31:0]        seed_i,
    output logic               seed_ready_o,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [31:0]        rnd_o,
`ifdef LFSR_ARB_DRAW_CNT_EN
    output logic [15:0]        draw_cnt_o,
`endif
    output logic               busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_t;

    localparam state_t INIT_STATE = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

    // One LFSR advance; an all-zero result would lock the register, so fall back to the default seed.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = {cur[30:0], cur[27] ^ cur[23] ^ cur[19] ^ cur[18] ^ cur[15]
                        ^ cur[11] ^ cur[7] ^ cur[4] ^ cur[1]};
        return (nxt == 32'h0) ? DEFAULT_SEED : nxt;
    endfunction

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [31:0]        rnd_d;
    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   win;
    logic               found;
`ifdef LFSR_ARB_DRAW_CNT_EN
    logic [15:0]        draw_q, draw_d;
`endif

    // A requester granted last cycle sits out one cycle, so a held request gets every other word.
    always_comb begin
        eligible = req_i & ~gnt_o;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rnd_d   = rnd_o;
`ifdef LFSR_ARB_DRAW_CNT_EN
        draw_d  = draw_q;
`endif
        case (state_q)
            ST_WARMUP: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (seed_valid_i) begin
                    // A seed offer beats any pending request; the pointer is left alone.
                    lfsr_d  = (seed_i == 32'h0) ? DEFAULT_SEED : seed_i;
                    cnt_d   = '0;
                    state_d = INIT_STATE;
`ifdef LFSR_ARB_DRAW_CNT_EN
                    draw_d  = '0;
`endif
                end else if (found) begin
                    gnt_d  = NUM_REQ'(1) << win;
                    rnd_d  = lfsr_q;
                    lfsr_d = lfsr_step(lfsr_q);
                    ptr_d  = PTR_W'((int'(win) + 1) % NUM_REQ);
`ifdef LFSR_ARB_DRAW_CNT_EN
                    draw_d = (draw_q == 16'hFFFF) ? draw_q : draw_q + 16'd1;
`endif
                end
            end
            default: state_d = INIT_STATE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= INIT_STATE;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_o   <= '0;
            rnd_o   <= '0;
`ifdef LFSR_ARB_DRAW_CNT_EN
            draw_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_o   <= gnt_d;
            rnd_o   <= rnd_d;
`ifdef LFSR_ARB_DRAW_CNT_EN
            draw_q  <= draw_d;
`endif
        end
    end

    assign busy_o       = (state_q == ST_WARMUP);
    assign seed_ready_o = (state_q == ST_RUN);
`ifdef LFSR_ARB_DRAW_CNT_EN
    assign draw_cnt_o   = draw_q;
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: one instance without warm-up (a_*) and one with 16 warm-up cycles (b_*).
// Grant-counter checks are compiled in when LFSR_ARB_DRAW_CNT_EN is defined.
module tb_lfsr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_seed_valid, a_seed_ready, a_busy;
    logic [31:0] a_seed, a_rnd;
    logic [3:0]  a_req, a_gnt;
    logic        b_reset, b_seed_valid, b_seed_ready, b_busy;
    logic [31:0] b_seed, b_rnd;
    logic [3:0]  b_req, b_gnt;
`ifdef LFSR_ARB_DRAW_CNT_EN
    logic [15:0] a_draw, b_draw;
`endif

    lfsr_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(0)) dut_a (
        .clk_i(clk), .reset_i(a_reset), .seed_valid_i(a_seed_valid), .seed_i(a_seed),
        .seed_ready_o(a_seed_ready), .req_i(a_req), .gnt_o(a_gnt), .rnd_o(a_rnd),
`ifdef LFSR_ARB_DRAW_CNT_EN
        .draw_cnt_o(a_draw),
`endif
        .busy_o(a_busy)
    );

    lfsr_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(16)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .seed_valid_i(b_seed_valid), .seed_i(b_seed),
        .seed_ready_o(b_seed_ready), .req_i(b_req), .gnt_o(b_gnt), .rnd_o(b_rnd),
`ifdef LFSR_ARB_DRAW_CNT_EN
        .draw_cnt_o(b_draw),
`endif
        .busy_o(b_busy)
    );

    // Reference step: feedback is the parity of the tapped bits (taps 27,23,19,18,15,11,7,4,1).
    function automatic logic [31:0] ref_step(input logic [31:0] v);
        logic [31:0] n;
        n = {v[30:0], ^(v & 32'h088C8892)};
        if (n == 32'h0) n = 32'h00B41AFD;
        return n;
    endfunction

    function automatic logic [31:0] ref_adv(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = ref_step(r);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] alt_words [3];
    logic [3:0]  rr_order  [5];
    logic [31:0] prev, ws;

    initial begin
        alt_words = '{32'h02D06BF6, 32'h05A0D7ED, 32'h0B41AFDB};
        rr_order  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        a_reset = 1'b1; a_seed_valid = 1'b0; a_seed = '0; a_req = '0;
        b_reset = 1'b1; b_seed_valid = 1'b0; b_seed = '0; b_req = '0;
        tick();
        tick();

        check("a_rst_gnt", a_gnt, 4'b0000);
        check("a_rst_rnd", a_rnd, 32'h0);
        check("a_rst_busy", a_busy, 1'b0);
        check("a_rst_seed_ready", a_seed_ready, 1'b1);
        check("b_rst_gnt", b_gnt, 4'b0000);
        check("b_rst_rnd", b_rnd, 32'h0);
        check("b_rst_busy", b_busy, 1'b1);
        check("b_rst_seed_ready", b_seed_ready, 1'b0);

        // No warm-up: first grant returns the default seed, next grant its successor.
        a_reset = 1'b0; a_req = 4'b0100;
        tick();
        check("a_first_gnt", a_gnt, 4'b0100);
        check("a_first_rnd", a_rnd, 32'h00B41AFD);
        a_req = 4'b0000;
        tick();
        check("a_idle_gnt", a_gnt, 4'b0000);
        check("a_idle_rnd_hold", a_rnd, 32'h00B41AFD);
        a_req = 4'b0001;
        tick();
        check("a_second_gnt", a_gnt, 4'b0001);
        check("a_second_rnd", a_rnd, 32'h016835FB);

        // Held single request alternates grant / no grant with successive distinct words.
        prev = 32'h016835FB;
        for (int g = 0; g < 3; g++) begin
            tick();
            check("a_mask_gnt", a_gnt, 4'b0000);
            check("a_mask_rnd_hold", a_rnd, prev);
            tick();
            check("a_alt_gnt", a_gnt, 4'b0001);
            check("a_alt_rnd", a_rnd, alt_words[g]);
            prev = alt_words[g];
        end
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("a_draw_5", a_draw, 16'd5);
`endif
        a_req = 4'b0000;
        tick();
        check("a_release_gnt", a_gnt, 4'b0000);

        // Seed and request in the same cycle: the seed wins, no grant.
        a_seed_valid = 1'b1; a_seed = 32'h80000000; a_req = 4'b0010;
        check("a_seed_ready_run", a_seed_ready, 1'b1);
        tick();
        check("a_seed_wins_gnt", a_gnt, 4'b0000);
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("a_draw_seed_clr", a_draw, 16'd0);
`endif
        a_seed_valid = 1'b0;
        tick();
        check("a_seed_gnt", a_gnt, 4'b0010);
        check("a_seed_rnd", a_rnd, 32'h80000000);
        a_req = 4'b0100;
        tick();
        check("a_lockup_gnt", a_gnt, 4'b0100);
        check("a_lockup_rnd", a_rnd, 32'h00B41AFD);

        // Zero seed substitutes the default; pointer (now 3) survives the seed accept.
        a_req = 4'b0000; a_seed_valid = 1'b1; a_seed = 32'h0;
        tick();
        check("a_zseed_gnt", a_gnt, 4'b0000);
        a_seed_valid = 1'b0; a_req = 4'b1111;
        tick();
        check("a_zseed_ptr_gnt", a_gnt, 4'b1000);
        check("a_zseed_rnd", a_rnd, 32'h00B41AFD);
        tick();
        check("a_zseed_wrap_gnt", a_gnt, 4'b0001);
        check("a_zseed_rnd2", a_rnd, 32'h016835FB);
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("a_draw_2", a_draw, 16'd2);
`endif
        a_req = 4'b0000;

        // Warm-up instance: busy for exactly 16 cycles, no grants, seed offers ignored.
        b_reset = 1'b0; b_req = 4'b1111; b_seed_valid = 1'b1; b_seed = 32'h12345678;
        for (int i = 0; i < 16; i++) begin
            check("b_warm_busy", b_busy, 1'b1);
            check("b_warm_gnt", b_gnt, 4'b0000);
            check("b_warm_seed_ready", b_seed_ready, 1'b0);
            if (i == 15) b_seed_valid = 1'b0;
            tick();
        end
        check("b_run_busy", b_busy, 1'b0);
        check("b_run_gnt", b_gnt, 4'b0000);
        check("b_run_seed_ready", b_seed_ready, 1'b1);

        ws = ref_adv(32'h00B41AFD, 16);
        for (int g = 0; g < 5; g++) begin
            tick();
            check("b_rr_gnt", b_gnt, rr_order[g]);
            check("b_rr_rnd", b_rnd, ws);
            ws = ref_step(ws);
        end
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("b_draw_5", b_draw, 16'd5);
`endif

        // Seed accept re-enters warm-up; pointer (1) is kept for the first grant after it.
        b_seed_valid = 1'b1; b_seed = 32'h00000001;
        tick();
        b_seed_valid = 1'b0;
        check("b_seed_gnt", b_gnt, 4'b0000);
        check("b_seed_busy", b_busy, 1'b1);
        check("b_seed_seed_ready", b_seed_ready, 1'b0);
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("b_draw_seed_clr", b_draw, 16'd0);
`endif
        for (int i = 1; i < 16; i++) begin
            tick();
            check("b_rewarm_busy", b_busy, 1'b1);
            check("b_rewarm_gnt", b_gnt, 4'b0000);
        end
        tick();
        check("b_rerun_busy", b_busy, 1'b0);
        tick();
        check("b_ptr_kept_gnt", b_gnt, 4'b0010);
        check("b_seeded_rnd", b_rnd, ref_adv(32'h00000001, 16));
        tick();
        check("b_next_gnt", b_gnt, 4'b0100);

        // Reset in the middle of a grant stream.
        b_reset = 1'b1;
        tick();
        check("b_midrst_gnt", b_gnt, 4'b0000);
        check("b_midrst_rnd", b_rnd, 32'h0);
        check("b_midrst_busy", b_busy, 1'b1);
        check("b_midrst_seed_ready", b_seed_ready, 1'b0);
`ifdef LFSR_ARB_DRAW_CNT_EN
        check("b_draw_rst", b_draw, 16'd0);
`endif
        b_reset = 1'b0;
        tick();
        check("b_post_rst_gnt", b_gnt, 4'b0000);
        check("b_post_rst_busy", b_busy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
